// File: rtl/stream_pingpong_cache.sv
// Two-bank ping-pong word cache in front of the hash stage: fills one bank from the stream while the
// other bank is read at random by index. A completed block is handed back to the fill side on complete.
module stream_pingpong_cache #(
  parameter int LENGTH_ARRAY     = 100,
  parameter int DATA_INDEX_WIDTH = 32,
  parameter int CNT_WIDTH        = 16,
  localparam int LENGTH_ARRAY_WIDTH_BIT = (LENGTH_ARRAY > 1) ? $clog2(LENGTH_ARRAY) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_INDEX_WIDTH-1:0]       s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              data_request,
  input  logic                              complete,
  input  logic [LENGTH_ARRAY_WIDTH_BIT-1:0] index,
  output logic [DATA_INDEX_WIDTH-1:0]       data_stream,
  output logic                              cache_enough,
  output logic [1:0]                        bank_full,
  output logic [CNT_WIDTH-1:0]              blocks_done,
  output logic [CNT_WIDTH-1:0]              starve_cycles,
  output logic                              protocol_err
);

  localparam int AW = LENGTH_ARRAY_WIDTH_BIT;
  localparam logic [AW-1:0] LAST_IDX = AW'(LENGTH_ARRAY - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(LENGTH_ARRAY);

  logic [DATA_INDEX_WIDTH-1:0] mem0 [LENGTH_ARRAY];
  logic [DATA_INDEX_WIDTH-1:0] mem1 [LENGTH_ARRAY];

  logic          fbank;
  logic          rbank;
  logic [AW-1:0] wr_cnt;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_en;
  logic          fill_done;
  logic          release_blk;
  logic [DATA_INDEX_WIDTH-1:0] rd_word;

  assign s_ready      = !full[fbank];
  assign wr_en        = s_valid && s_ready;
  assign fill_done    = wr_en && (wr_cnt == LAST_IDX);
  assign release_blk  = complete && full[rbank];
  assign cache_enough = full[rbank];
  assign bank_full    = full;

  // fbank == rbank implies that bank is either filling or full, so the two updates never collide
  always_comb begin
    full_nxt = full;
    if (fill_done)   full_nxt[fbank] = 1'b1;
    if (release_blk) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fbank         <= 1'b0;
      rbank         <= 1'b0;
      wr_cnt        <= '0;
      full          <= 2'b00;
      blocks_done   <= '0;
      starve_cycles <= '0;
      protocol_err  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        if (fill_done) begin
          wr_cnt <= '0;
          fbank  <= ~fbank;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
      if (release_blk) begin
        rbank       <= ~rbank;
        blocks_done <= blocks_done + CNT_WIDTH'(1);
      end
      if (complete && !full[rbank]) protocol_err <= 1'b1;
      if (data_request && !(&starve_cycles)) starve_cycles <= starve_cycles + CNT_WIDTH'(1);
    end
  end

  // Bank storage carries no reset; the full flags alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (fbank) mem1[wr_cnt] <= s_data;
      else       mem0[wr_cnt] <= s_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (full[rbank] && ({1'b0, index} < DEPTH)) rd_word = rbank ? mem1[index] : mem0[index];
  end

  assign data_stream = rd_word;

endmodule

// File: tb/tb_stream_pingpong_cache.sv
// Directed bench for stream_pingpong_cache with 4-word blocks; expected values are hand-derived.
module tb_stream_pingpong_cache;

  localparam int LA  = 4;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          data_request;
  logic          complete;
  logic [IW-1:0] index;
  logic [DW-1:0] data_stream;
  logic          cache_enough;
  logic [1:0]    bank_full;
  logic [CW-1:0] blocks_done;
  logic [CW-1:0] starve_cycles;
  logic          protocol_err;

  int checks = 0;
  int errors = 0;

  stream_pingpong_cache #(
    .LENGTH_ARRAY(LA), .DATA_INDEX_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .data_request(data_request), .complete(complete), .index(index),
    .data_stream(data_stream), .cache_enough(cache_enough), .bank_full(bank_full),
    .blocks_done(blocks_done), .starve_cycles(starve_cycles), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    s_data  = w;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic read_at(input logic [IW-1:0] i, input logic [31:0] exp, input string tag);
    index = i;
    #1;
    check(tag, data_stream, exp);
  endtask

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; data_request = 1'b0; complete = 1'b0; index = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_cache_enough", 32'(cache_enough), 32'd0);
    check("rst_data_stream", data_stream, 32'd0);
    check("rst_bank_full", 32'(bank_full), 32'd0);
    check("rst_blocks_done", 32'(blocks_done), 32'd0);
    check("rst_starve", 32'(starve_cycles), 32'd0);
    check("rst_perr", 32'(protocol_err), 32'd0);

    // complete with nothing cached
    complete = 1'b1; step(); complete = 1'b0;
    check("empty_cpl_perr", 32'(protocol_err), 32'd1);
    check("empty_cpl_blocks", 32'(blocks_done), 32'd0);

    // first block
    for (int w = 1; w <= 4; w++) begin
      check($sformatf("t1_ce_before_%0d", w), 32'(cache_enough), 32'd0);
      push(32'(w));
    end
    check("t1_cache_enough", 32'(cache_enough), 32'd1);
    read_at(2'd2, 32'd3, "t1_idx2");
    read_at(2'd0, 32'd1, "t1_idx0");
    check("t1_bank_full", 32'(bank_full), 32'b01);
    check("t1_s_ready", 32'(s_ready), 32'd1);

    // second block fills the idle bank, then word 9 stalls
    for (int w = 5; w <= 8; w++) push(32'(w));
    check("t2_bank_full", 32'(bank_full), 32'b11);
    check("t2_s_ready", 32'(s_ready), 32'd0);
    s_data = 32'd9; s_valid = 1'b1;
    step();
    check("t2_held_ready", 32'(s_ready), 32'd0);
    check("t2_held_full", 32'(bank_full), 32'b11);
    read_at(2'd3, 32'd4, "t2_bank0_idx3");
    complete = 1'b1; step(); complete = 1'b0;
    check("t2_blocks_done", 32'(blocks_done), 32'd1);
    check("t2_bank_full_rel", 32'(bank_full), 32'b10);
    check("t2_ce_after_rel", 32'(cache_enough), 32'd1);
    check("t2_ready_after_rel", 32'(s_ready), 32'd1);
    read_at(2'd0, 32'd5, "t2_idx0");
    read_at(2'd3, 32'd8, "t2_idx3");
    step();
    s_valid = 1'b0;
    check("t2_perr_sticky", 32'(protocol_err), 32'd1);

    // finish bank0 fill in the same cycle bank1 is released
    push(32'd10);
    push(32'd11);
    check("t4_pre_full", 32'(bank_full), 32'b10);
    complete = 1'b1;
    push(32'd12);
    complete = 1'b0;
    check("t4_bank_full", 32'(bank_full), 32'b01);
    check("t4_cache_enough", 32'(cache_enough), 32'd1);
    check("t4_blocks_done", 32'(blocks_done), 32'd2);
    check("t4_s_ready", 32'(s_ready), 32'd1);
    read_at(2'd0, 32'd9, "t4_idx0");
    read_at(2'd3, 32'd12, "t4_idx3");

    // starvation counter
    data_request = 1'b1;
    repeat (3) step();
    check("t5_starve3", 32'(starve_cycles), 32'd3);
    check("t5_full_unchanged", 32'(bank_full), 32'b01);
    repeat (65535) step();
    check("t5_starve_sat", 32'(starve_cycles), 32'h0000FFFF);
    step();
    check("t5_starve_hold", 32'(starve_cycles), 32'h0000FFFF);
    data_request = 1'b0;

    // reset partway into a fill of bank1
    push(32'd20);
    push(32'd21);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    #1;
    check("t6_bank_full", 32'(bank_full), 32'd0);
    check("t6_s_ready", 32'(s_ready), 32'd1);
    check("t6_cache_enough", 32'(cache_enough), 32'd0);
    check("t6_blocks_done", 32'(blocks_done), 32'd0);
    check("t6_starve", 32'(starve_cycles), 32'd0);
    check("t6_perr", 32'(protocol_err), 32'd0);
    check("t6_data_stream", data_stream, 32'd0);
    for (int w = 30; w <= 33; w++) push(32'(w));
    check("t6_refill_full", 32'(bank_full), 32'b01);
    read_at(2'd0, 32'd30, "t6_idx0");
    read_at(2'd3, 32'd33, "t6_idx3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
